pwm_sample_decoder: RTL and testbench

- Receive-side counterpart of the chip's PWM audio output (sigout).
- Recovers the per-frame sample value from a PWM waveform fed back through a breakout-board GPIO pin, for loopback self-test and board bring-up.
- Locks to frame boundaries, measures the high time of each frame and emits one sample per frame with a valid strobe.
- Flags frames with the wrong period or with the line stuck high.

---
 rtl/pwm_sample_decoder_pkg.sv | 13 +
 rtl/pwm_sample_decoder_sync_edge_detect.sv | 29 ++
 rtl/pwm_sample_decoder.sv | 129 ++++++++++++
 tb/tb_pwm_sample_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sample_decoder_pkg.sv
// Shared definitions for the PWM audio path: decoder states and the frame
// geometry that the PWM generator and this decoder must agree on.
package pwm_sample_decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int PWM_SAMPLE_W = 8;
    localparam int PWM_PERIOD   = 256;

endpackage

// File: rtl/pwm_sample_decoder_sync_edge_detect.sv
// Brings the asynchronous pad signal into the clk domain and flags its rising
// edges one cycle wide.
module pwm_sample_decoder_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_s_d;

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers one sample per PWM frame from the looped-back sigout waveform by
// counting high cycles between frame boundaries; flags period violations.
module pwm_sample_decoder
    import pwm_sample_decoder_pkg::*;
#(
    parameter int SAMPLE_W    = PWM_SAMPLE_W,
    parameter int PERIOD      = PWM_PERIOD,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sigout_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                frame_err,
    output logic                locked,
    output logic [7:0]          err_cnt
);

    localparam int                PCNT_W     = $clog2(PERIOD) + 1;
    localparam logic [PCNT_W-1:0] PERIOD_END = PCNT_W'(PERIOD);

    // A frame that stayed high throughout and then fell at the boundary counts
    // PERIOD highs, which does not fit in SAMPLE_W bits; clamp to full scale.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] v);
        return v[SAMPLE_W] ? {SAMPLE_W{1'b1}} : v[SAMPLE_W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              w_s;
    logic              w_rise;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_frame_start;
    logic              w_emit;
    logic              w_err;
    logic [PCNT_W-1:0] r_period_cnt;
    logic [SAMPLE_W:0] r_high_cnt;
    logic [SAMPLE_W-1:0] r_sample;
    logic              r_sample_valid;
    logic              r_frame_err;
    logic [7:0]        r_err_cnt;

    pwm_sample_decoder_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (sigout_in),
        .o_s    (w_s),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_emit        = 1'b0;
        w_err         = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt   = TRACK;
                        w_frame_start = 1'b1;
                    end
                end
                TRACK: begin
                    if (r_period_cnt == PERIOD_END) begin
                        // A low line at the boundary is a legal zero-duty frame.
                        if (w_rise || !w_s) begin
                            w_emit        = 1'b1;
                            w_frame_start = 1'b1;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end else if (w_rise) begin
                        w_err         = 1'b1;
                        w_frame_start = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Frame counters are always reloaded at lock, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_frame_start) begin
            r_period_cnt <= PCNT_W'(1);
            r_high_cnt   <= {{SAMPLE_W{1'b0}}, w_s};
        end else if (r_state == TRACK && w_state_nxt == TRACK) begin
            r_period_cnt <= r_period_cnt + PCNT_W'(1);
            r_high_cnt   <= r_high_cnt + {{SAMPLE_W{1'b0}}, w_s};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            r_err_cnt      <= 8'd0;
        end else begin
            r_sample_valid <= w_emit;
            r_frame_err    <= w_err;
            if (w_emit) r_sample  <= sat_sample(r_high_cnt);
            if (w_err)  r_err_cnt <= sat_inc8(r_err_cnt);
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign frame_err    = r_frame_err;
    assign locked       = (r_state == TRACK);
    assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Bench for pwm_sample_decoder: waveforms are built as bit queues and checked
// cycle by cycle against a frame-level reference model.
module tb_pwm_sample_decoder;

    localparam int SW   = 8;
    localparam int PER  = 256;
    localparam int SYNC = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          sigout_in;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          frame_err;
    logic          locked;
    logic [7:0]    err_cnt;

    int checks   = 0;
    int failures = 0;

    bit wave[$];
    int m_smp;
    int m_err;
    int r_nvalid;
    int r_first;
    int r_last;

    typedef struct packed {
        int duty;
        int frames;
        int low_frames;
        int exp_nvalid;
        int exp_last;
        int exp_first;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    pwm_sample_decoder #(
        .SAMPLE_W    (SW),
        .PERIOD      (PER),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .sigout_in    (sigout_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked),
        .err_cnt      (err_cnt)
    );

    task automatic check_eq(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic add_const(input bit v, input int n);
        repeat (n) wave.push_back(v);
    endtask

    task automatic add_frame(input int duty);
        add_const(1'b1, duty);
        add_const(1'b0, PER - duty);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b1;
        sigout_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_smp = 0;
        m_err = 0;
        wave.delete();
    endtask

    function automatic string sig_name(input int s);
        case (s)
            0:       return "sample_valid";
            1:       return "frame_err";
            2:       return "locked";
            3:       return "sample";
            default: return "err_cnt";
        endcase
    endfunction

    // Reference: walk the waveform frame by frame. A frame is a window of PER
    // cycles that starts at a rise; its sample is the number of high cycles
    // in the window. Outputs appear SYNC cycles after the input index.
    task automatic run_wave(input string tag);
        int n, fs, hi, errs, smp, j;
        bit lk, prev, rise;
        bit exp_v[], exp_e[], lk_a[];
        int smp_a[], err_a[];
        int mm[5], cyc[5], act[5], req[5], now_a[5], now_r[5];
        n = wave.size();
        exp_v = new[n + SYNC];
        exp_e = new[n + SYNC];
        lk_a  = new[n];
        smp_a = new[n];
        err_a = new[n];
        lk   = 1'b0;
        fs   = 0;
        smp  = m_smp;
        errs = m_err;
        for (int i = 0; i < n; i++) begin
            prev = (i == 0) ? 1'b0 : wave[i-1];
            rise = wave[i] && !prev;
            if (!lk) begin
                if (rise) begin
                    lk = 1'b1;
                    fs = i;
                end
            end else if (i - fs == PER) begin
                hi = 0;
                for (int t = fs; t < i; t++) hi += int'(wave[t]);
                if (rise || !wave[i]) begin
                    exp_v[i+SYNC] = 1'b1;
                    smp = (hi > SMAX) ? SMAX : hi;
                    fs  = i;
                end else begin
                    exp_e[i+SYNC] = 1'b1;
                    lk = 1'b0;
                    if (errs < 255) errs++;
                end
            end else if (rise) begin
                exp_e[i+SYNC] = 1'b1;
                fs = i;
                if (errs < 255) errs++;
            end
            lk_a[i]  = lk;
            smp_a[i] = smp;
            err_a[i] = errs;
        end
        for (int s = 0; s < 5; s++) begin
            mm[s] = 0; cyc[s] = 0; act[s] = 0; req[s] = 0;
        end
        r_nvalid = 0;
        r_first  = -1;
        r_last   = -1;
        for (int k = 0; k < n; k++) begin
            sigout_in = wave[k];
            @(posedge clk);
            #1;
            j = k - SYNC;
            now_a[0] = int'(sample_valid); now_r[0] = int'(exp_v[k]);
            now_a[1] = int'(frame_err);    now_r[1] = int'(exp_e[k]);
            now_a[2] = int'(locked);       now_r[2] = (j >= 0) ? int'(lk_a[j]) : 0;
            now_a[3] = int'(sample);       now_r[3] = (j >= 0) ? smp_a[j] : m_smp;
            now_a[4] = int'(err_cnt);      now_r[4] = (j >= 0) ? err_a[j] : m_err;
            for (int s = 0; s < 5; s++) begin
                if (now_a[s] != now_r[s]) begin
                    if (mm[s] == 0) begin
                        cyc[s] = k; act[s] = now_a[s]; req[s] = now_r[s];
                    end
                    mm[s]++;
                end
            end
            if (sample_valid) begin
                r_nvalid++;
                if (r_first < 0) r_first = k;
                r_last = int'(sample);
            end
        end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (mm[s] != 0) begin
                failures++;
                $display("FAIL %s %s: cycle %0d actual=%0d required=%0d (%0d bad cycles)",
                         tag, sig_name(s), cyc[s], act[s], req[s], mm[s]);
            end
        end
        if (n > 0) begin
            m_smp = smp_a[n-1];
            m_err = err_a[n-1];
        end
    endtask

    int nf, p, len, bad_v, bad_e, bad_l, bad_s, bad_c;
    bit v;

    initial begin
        tbl[0] = '{duty: 100, frames: 5, low_frames: 0, exp_nvalid: 4, exp_last: 100, exp_first: 261};
        tbl[1] = '{duty: 50,  frames: 2, low_frames: 3, exp_nvalid: 4, exp_last: 0,   exp_first: 261};
        tbl[2] = '{duty: 255, frames: 4, low_frames: 0, exp_nvalid: 3, exp_last: 255, exp_first: 261};
        tbl[3] = '{duty: 1,   frames: 3, low_frames: 0, exp_nvalid: 2, exp_last: 1,   exp_first: 261};

        reset     = 1'b1;
        en        = 1'b1;
        sigout_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset sample", int'(sample), 0);
        check_eq("reset sample_valid", int'(sample_valid), 0);
        check_eq("reset frame_err", int'(frame_err), 0);
        check_eq("reset locked", int'(locked), 0);
        check_eq("reset err_cnt", int'(err_cnt), 0);
        reset = 1'b0;

        for (int e = 0; e < 4; e++) begin
            do_reset();
            add_const(1'b0, 3);
            for (int f = 0; f < tbl[e].frames; f++) add_frame(tbl[e].duty);
            add_const(1'b0, tbl[e].low_frames * PER);
            run_wave($sformatf("vec%0d", e));
            check_eq($sformatf("vec%0d valid count", e), r_nvalid, tbl[e].exp_nvalid);
            check_eq($sformatf("vec%0d last sample", e), r_last, tbl[e].exp_last);
            check_eq($sformatf("vec%0d first valid cycle", e), r_first, tbl[e].exp_first);
            check_eq($sformatf("vec%0d err_cnt", e), int'(err_cnt), 0);
        end

        for (int r = 0; r < 6; r++) begin
            do_reset();
            add_const(1'b0, $urandom_range(1, 5));
            nf = $urandom_range(3, 5);
            for (int f = 0; f < nf; f++) add_frame($urandom_range(0, SMAX));
            if ($urandom_range(0, 1) == 1) begin
                p   = $urandom_range(10, wave.size() - 10);
                len = $urandom_range(1, 300);
                v   = ($urandom_range(0, 1) == 1);
                for (int t = p; t < p + len && t < wave.size(); t++) wave[t] = v;
            end
            run_wave($sformatf("rand%0d", r));
        end

        // Extra rise 200 cycles into a duty-80 frame.
        do_reset();
        add_const(1'b0, 3);
        add_frame(80);
        add_frame(80);
        add_const(1'b1, 80);
        add_const(1'b0, 120);
        for (int f = 0; f < 3; f++) add_frame(80);
        run_wave("early_rise");
        check_eq("early_rise err_cnt", int'(err_cnt), 1);
        check_eq("early_rise valid count", r_nvalid, 4);
        check_eq("early_rise last sample", r_last, 80);

        // Line stuck high for 300 cycles while locked, then relock.
        do_reset();
        add_const(1'b0, 3);
        add_frame(60);
        add_frame(60);
        add_const(1'b1, 300);
        add_const(1'b0, 20);
        add_frame(60);
        add_frame(60);
        run_wave("stuck_high");
        check_eq("stuck_high err_cnt", int'(err_cnt), 1);
        check_eq("stuck_high valid count", r_nvalid, 3);
        check_eq("stuck_high sample", int'(sample), 60);
        check_eq("stuck_high relocked", int'(locked), 1);

        // Every other cycle is an early rise: err_cnt must stop at 255.
        do_reset();
        add_const(1'b0, 3);
        for (int t = 0; t < 300; t++) begin
            wave.push_back(1'b1);
            wave.push_back(1'b0);
        end
        run_wave("saturate");
        check_eq("saturate err_cnt", int'(err_cnt), 255);

        // Reset asserted 130 cycles into a frame, between clock edges.
        do_reset();
        add_const(1'b0, 3);
        add_frame(100);
        add_frame(100);
        add_const(1'b1, 100);
        add_const(1'b0, 50);
        add_const(1'b1, 100);
        add_const(1'b0, 30);
        run_wave("pre_reset");
        check_eq("pre_reset locked", int'(locked), 1);
        check_eq("pre_reset err_cnt", int'(err_cnt), 1);
        check_eq("pre_reset sample", int'(sample), 100);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async reset sample", int'(sample), 0);
        check_eq("async reset sample_valid", int'(sample_valid), 0);
        check_eq("async reset frame_err", int'(frame_err), 0);
        check_eq("async reset locked", int'(locked), 0);
        check_eq("async reset err_cnt", int'(err_cnt), 0);
        sigout_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_smp = 0;
        m_err = 0;
        wave.delete();
        add_const(1'b0, 5);
        add_frame(100);
        add_frame(100);
        run_wave("post_reset");
        check_eq("post_reset valid count", r_nvalid, 1);
        check_eq("post_reset first valid cycle", r_first, 263);

        // One frame with en low, then relock once en returns.
        do_reset();
        add_const(1'b0, 3);
        add_frame(70);
        add_frame(70);
        run_wave("pre_en");
        en    = 1'b0;
        bad_v = 0; bad_e = 0; bad_l = 0; bad_s = 0; bad_c = 0;
        for (int k = 0; k < PER; k++) begin
            sigout_in = (k < 70);
            @(posedge clk);
            #1;
            if (sample_valid)        bad_v++;
            if (frame_err)           bad_e++;
            if (locked)              bad_l++;
            if (int'(sample) != 70)  bad_s++;
            if (int'(err_cnt) != 0)  bad_c++;
        end
        check_eq("en_low valid cycles", bad_v, 0);
        check_eq("en_low frame_err cycles", bad_e, 0);
        check_eq("en_low locked cycles", bad_l, 0);
        check_eq("en_low sample changed cycles", bad_s, 0);
        check_eq("en_low err_cnt changed cycles", bad_c, 0);
        en = 1'b1;
        wave.delete();
        for (int f = 0; f < 3; f++) add_frame(70);
        run_wave("en_relock");
        check_eq("en_relock valid count", r_nvalid, 2);
        check_eq("en_relock first valid cycle", r_first, 258);
        check_eq("en_relock locked", int'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
